// File: rtl/toggle_event_collector.sv
// Purpose : gathers toggle-encoded async events per channel, counts them, and presents them one at a time in round-robin order.
// Latency : a toggleIn transition sampled at edge k is counted at edge k+SYNC_STAGES and presented (eventValid) at edge k+SYNC_STAGES+1.
// Backpressure: eventValid/eventChannel hold until eventReady; meanwhile events accumulate in saturating per-channel counters, and an overflow sets a sticky flag.
//
// Ports:
//   clk           : single clock, all state on the rising edge
//   resetN        : asynchronous active-low reset
//   toggleIn      : [CHANNELS] async toggle-encoded events (each edge = one event)
//   eventValid    : an event is presented on eventChannel
//   eventReady    : consumer accepts the presented event
//   eventChannel  : [IDW] channel index of the presented event
//   pendingAny    : some per-channel counter is nonzero (the presented event is not included)
//   overflow      : [CHANNELS] sticky lost-event flags
//   overflowClear : clears all overflow flags on the next edge
module toggle_event_collector #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 4,
  localparam int IDW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [CHANNELS-1:0] toggleIn,
  output logic                eventValid,
  input  logic                eventReady,
  output logic [IDW-1:0]      eventChannel,
  output logic                pendingAny,
  output logic [CHANNELS-1:0] overflow,
  input  logic                overflowClear
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  // Reset value of the last grant: the last channel, so the first search starts at channel 0.
  localparam logic [IDW-1:0]         LAST_CH = IDW'(CHANNELS - 1);

  logic [CHANNELS-1:0]    sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]    hist_q;
  logic [CHANNELS-1:0]    detect;
  logic [COUNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CHANNELS-1:0]    nonzero;
  logic [CHANNELS-1:0]    dec;
  logic [CHANNELS-1:0]    ovf_set;
  logic [CHANNELS-1:0]    overflow_q;

  state_t                 state_q;
  state_t                 state_d;
  logic [IDW-1:0]         chan_q;
  logic [IDW-1:0]         last_q;
  logic [IDW-1:0]         base;
  logic [IDW-1:0]         pick_hi;
  logic [IDW-1:0]         pick_lo;
  logic [IDW-1:0]         pick;
  logic                   hi_found;
  logic                   any_pending;
  logic                   accept;
  logic                   load;

  // ---------------------------------------------------------------------------
  // Synchronizer chain plus one history flop per channel. Reset clears the
  // history to 0, so a toggleIn held at 1 through reset yields exactly one event.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      hist_q <= '0;
    end else begin
      sync_q[0] <= toggleIn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign detect = sync_q[SYNC_STAGES-1] ^ hist_q;

  always_comb begin
    nonzero = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      nonzero[c] = (cnt_q[c] != '0);
    end
  end

  assign any_pending = |nonzero;
  assign accept      = (state_q == PRESENT) && eventReady;

  // On an accept the grant being retired becomes the new "last granted", so the
  // back-to-back search must already start after it in this same cycle.
  assign base = accept ? chan_q : last_q;

  // ---------------------------------------------------------------------------
  // Round-robin pick: the lowest pending channel above base wins; if there is none,
  // wrap to the lowest pending channel at or below base. Scanning downward
  // and overwriting leaves the lowest match in each half.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    hi_found = 1'b0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (nonzero[c]) begin
        if (c > int'(base)) begin
          pick_hi  = IDW'(c);
          hi_found = 1'b1;
        end else begin
          pick_lo  = IDW'(c);
        end
      end
    end
    pick = hi_found ? pick_hi : pick_lo;
  end

  // ---------------------------------------------------------------------------
  // Output FSM. A load reserves one event: its counter decrements on the same
  // edge as eventChannel is loaded.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (eventReady) begin
          if (any_pending) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      chan_q  <= '0;
      last_q  <= LAST_CH;
    end else begin
      state_q <= state_d;
      if (load) begin
        chan_q <= pick;
      end
      if (accept) begin
        last_q <= chan_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel saturating counters. A detect and a reservation on the same
  // channel in the same cycle cancel out: no change and no overflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    dec     = '0;
    ovf_set = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      dec[c]     = load && (pick == IDW'(c));
      ovf_set[c] = detect[c] && !dec[c] && (cnt_q[c] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (detect[c] && !dec[c]) begin
          if (cnt_q[c] != CNT_MAX) begin
            cnt_q[c] <= cnt_q[c] + COUNT_WIDTH'(1);
          end
        end else if (dec[c] && !detect[c]) begin
          cnt_q[c] <= cnt_q[c] - COUNT_WIDTH'(1);
        end
      end
    end
  end

  // A new overflow in the same cycle as a clear leaves its bit set.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      overflow_q <= '0;
    end else begin
      overflow_q <= ovf_set | (overflow_q & ~{CHANNELS{overflowClear}});
    end
  end

  assign eventValid   = (state_q == PRESENT);
  assign eventChannel = chan_q;
  assign pendingAny   = any_pending;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_toggle_event_collector.sv
// Purpose : self-checking bench for toggle_event_collector; directed scenarios, then randomized traffic against a reference model.
// Latency : outputs are compared every cycle on the falling edge against the model's state after the preceding rising edge.
// Backpressure: eventReady is driven both as fixed patterns and at random duty cycles.
module tb_toggle_event_collector;

  localparam int CH   = 4;
  localparam int S    = 2;
  localparam int CW   = 4;
  localparam int IDW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           resetN;
  logic [CH-1:0]  toggleIn;
  logic           eventValid;
  logic           eventReady;
  logic [IDW-1:0] eventChannel;
  logic           pendingAny;
  logic [CH-1:0]  overflow;
  logic           overflowClear;

  toggle_event_collector #(
    .CHANNELS   (CH),
    .SYNC_STAGES(S),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .toggleIn     (toggleIn),
    .eventValid   (eventValid),
    .eventReady   (eventReady),
    .eventChannel (eventChannel),
    .pendingAny   (pendingAny),
    .overflow     (overflow),
    .overflowClear(overflowClear)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending counts per channel, the presented event, the last
  // accepted channel, sticky overflow flags and recent toggleIn samples.
  int           m_cnt [CH];
  bit           m_valid;
  int           m_chan;
  int           m_last;
  bit [CH-1:0]  m_ovf;
  bit [CH-1:0]  m_samp [$];

  // Accepts observed on the DUT interface: channel and cycle number.
  int           acc_q [$];
  int           acc_t [$];
  int           tick_no;
  logic         obs_valid;
  logic [IDW-1:0] obs_chan;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) m_cnt[c] = 0;
    m_valid = 1'b0;
    m_chan  = 0;
    m_last  = CH - 1;
    m_ovf   = '0;
    m_samp.delete();
    repeat (S + 1) m_samp.push_back('0);
  endfunction

  // One rising edge of the design as described by its rules.
  function automatic void model_edge();
    bit [CH-1:0] det;
    bit [CH-1:0] ovf_new;
    bit          any;
    bit          acc;
    bit          load;
    int          pick;
    // An event is counted S edges after its transition was sampled: compare the
    // sample taken S edges ago against the one taken S+1 edges ago.
    det = m_samp[m_samp.size() - S] ^ m_samp[m_samp.size() - S - 1];
    m_samp.push_back(toggleIn);
    void'(m_samp.pop_front());

    any = 1'b0;
    for (int c = 0; c < CH; c++) if (m_cnt[c] > 0) any = 1'b1;
    acc = m_valid && eventReady;
    if (acc) m_last = m_chan;
    load = any && (!m_valid || acc);
    pick = -1;
    if (load) begin
      for (int i = 1; i <= CH; i++) begin
        if (pick < 0 && m_cnt[(m_last + i) % CH] > 0) pick = (m_last + i) % CH;
      end
      m_cnt[pick] = m_cnt[pick] - 1;
      m_chan  = pick;
      m_valid = 1'b1;
    end else if (acc) begin
      m_valid = 1'b0;
    end

    ovf_new = '0;
    for (int c = 0; c < CH; c++) begin
      if (det[c]) begin
        if (pick == c)            m_cnt[c] = m_cnt[c] + 1;
        else if (m_cnt[c] == CMAX) ovf_new[c] = 1'b1;
        else                       m_cnt[c] = m_cnt[c] + 1;
      end
    end
    if (overflowClear) m_ovf = '0;
    m_ovf |= ovf_new;
  endfunction

  function automatic int model_pending();
    int p = 0;
    for (int c = 0; c < CH; c++) if (m_cnt[c] > 0) p = 1;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (resetN && obs_valid && eventReady) begin
      acc_q.push_back(int'(obs_chan));
      acc_t.push_back(tick_no);
    end
    if (resetN) model_edge();
    tick_no++;
    @(negedge clk);
    expect_eq("valid", eventValid, m_valid);
    expect_eq("chan", eventChannel, m_chan);
    expect_eq("pending", pendingAny, model_pending());
    expect_eq("overflow", overflow, m_ovf);
    obs_valid = eventValid;
    obs_chan  = eventChannel;
  endtask

  // Asserts reset between edges, checks outputs clear at once, holds it for
  // some cycles with toggleIn = tin, then releases on a falling edge.
  task automatic do_reset(input int cycles, input logic [CH-1:0] tin);
    resetN   = 1'b0;
    toggleIn = tin;
    model_reset();
    #1;
    expect_eq("rst_valid", eventValid, 0);
    expect_eq("rst_chan", eventChannel, 0);
    expect_eq("rst_pending", pendingAny, 0);
    expect_eq("rst_overflow", overflow, 0);
    obs_valid = eventValid;
    obs_chan  = eventChannel;
    repeat (cycles) tick();
    resetN = 1'b1;
  endtask

  initial begin
    int lat;
    int rdy_pct;
    resetN        = 1'b0;
    toggleIn      = '0;
    eventReady    = 1'b0;
    overflowClear = 1'b0;
    obs_valid     = 1'b0;
    obs_chan      = '0;
    tick_no       = 0;
    do_reset(3, '0);

    // Single event on channel 2: latency and single-cycle presentation.
    eventReady = 1'b1;
    repeat (3) tick();
    acc_q.delete();
    toggleIn[2] = ~toggleIn[2];
    lat = 0;
    for (int i = 0; i < 12 && !eventValid; i++) begin
      tick();
      lat++;
    end
    expect_eq("lat_edges", lat - 1, S + 1);
    expect_eq("lat_chan", eventChannel, 2);
    tick();
    expect_eq("lat_single", eventValid, 0);
    expect_eq("lat_pending", pendingAny, 0);
    repeat (3) tick();
    expect_eq("lat_accepts", acc_q.size(), 1);
    if (acc_q.size() >= 1) expect_eq("lat_acc_ch", acc_q[0], 2);

    // Three events on channel 0 under backpressure, then drained.
    eventReady = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 3; i++) begin
      toggleIn[0] = ~toggleIn[0];
      repeat (4) tick();
    end
    repeat (4) tick();
    expect_eq("hold_valid", eventValid, 1);
    expect_eq("hold_chan", eventChannel, 0);
    expect_eq("hold_pending", pendingAny, 1);
    eventReady = 1'b1;
    repeat (8) tick();
    expect_eq("burst_accepts", acc_q.size(), 3);
    foreach (acc_q[i]) expect_eq("burst_ch", acc_q[i], 0);

    // Saturation: 17 events on channel 1 with no accepts.
    eventReady = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 17; i++) begin
      toggleIn[1] = ~toggleIn[1];
      repeat (2) tick();
    end
    repeat (4) tick();
    expect_eq("sat_overflow", overflow, 4'b0010);
    expect_eq("sat_chan", eventChannel, 1);
    overflowClear = 1'b1;
    tick();
    overflowClear = 1'b0;
    expect_eq("sat_clear", overflow, 0);
    eventReady = 1'b1;
    repeat (24) tick();
    expect_eq("sat_drain", acc_q.size(), CMAX + 1);
    expect_eq("sat_empty", pendingAny, 0);

    // All channels at once from reset: order 0,1,2,3, back to back, twice.
    do_reset(2, '0);
    eventReady = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      acc_q.delete();
      acc_t.delete();
      toggleIn = toggleIn ^ 4'hF;
      repeat (10) tick();
      expect_eq("rr_count", acc_q.size(), 4);
      foreach (acc_q[i]) begin
        expect_eq("rr_order", acc_q[i], i);
        if (i > 0) expect_eq("rr_gap", acc_t[i] - acc_t[i-1], 1);
      end
    end

    // Last grant was 3; channels 0 and 3 pending -> 0 first, then 3.
    eventReady = 1'b0;
    acc_q.delete();
    toggleIn[0] = ~toggleIn[0];
    toggleIn[3] = ~toggleIn[3];
    repeat (5) tick();
    expect_eq("wrap_valid", eventValid, 1);
    expect_eq("wrap_chan", eventChannel, 0);
    eventReady = 1'b1;
    repeat (4) tick();
    expect_eq("wrap_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      expect_eq("wrap_first", acc_q[0], 0);
      expect_eq("wrap_second", acc_q[1], 3);
    end

    // Reset while presenting with five more events pending.
    eventReady = 1'b0;
    toggleIn = toggleIn ^ 4'hF;
    repeat (2) tick();
    toggleIn = toggleIn ^ 4'h3;
    repeat (5) tick();
    expect_eq("mid_valid", eventValid, 1);
    expect_eq("mid_pending", pendingAny, 1);
    do_reset(2, '0);
    eventReady = 1'b1;
    acc_q.delete();
    repeat (10) tick();
    expect_eq("mid_no_events", acc_q.size(), 0);

    // toggleIn high through reset -> exactly one event per such channel.
    do_reset(2, 4'b0101);
    acc_q.delete();
    repeat (10) tick();
    expect_eq("rel_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      expect_eq("rel_first", acc_q[0], 0);
      expect_eq("rel_second", acc_q[1], 2);
    end

    // Randomized traffic with phases of light, medium and heavy backpressure.
    for (int n = 0; n < 3000; n++) begin
      case ((n / 400) % 3)
        0:       rdy_pct = 90;
        1:       rdy_pct = 50;
        default: rdy_pct = 5;
      endcase
      if ($urandom_range(0, 2) == 0) toggleIn = toggleIn ^ CH'($urandom);
      eventReady    = ($urandom_range(0, 99) < rdy_pct);
      overflowClear = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 700) == 0) do_reset($urandom_range(1, 3), CH'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toggle_event_collector.md
TOGGLE_EVENT_COLLECTOR -- requirements
Module: toggle_event_collector

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent toggle-event channels (legal 1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop depth per channel (legal 2..4).
REQ-003 SHALL have parameter COUNT_WIDTH, default 4, width of each per-channel pending-event counter (legal 1..8).
REQ-004 SHALL have derived width IDW = max(1, clog2(CHANNELS)).
REQ-005 SHALL have port clk  input  1  single clock; all state is on its rising edge.
REQ-006 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port toggleIn  input  CHANNELS  asynchronous toggle-encoded events, one bit per channel; each transition (0->1 or 1->0) is one event.
REQ-008 SHALL have port eventValid  output  1  an event is presented on eventChannel.
REQ-009 SHALL have port eventReady  input  1  consumer accepts the presented event.
REQ-010 SHALL have port eventChannel  output  IDW  channel index of the presented event.
REQ-011 SHALL have port pendingAny  output  1  OR of all per-channel counters being nonzero.
REQ-012 SHALL have port overflow  output  CHANNELS  sticky per-channel lost-event flags.
REQ-013 SHALL have port overflowClear  input  1  synchronous clear of all overflow bits.

Function
REQ-014 Each toggleIn bit SHALL pass through SYNC_STAGES flops, then one history flop; detect = lastStage XOR history (combinational, one cycle per transition).
REQ-015 A toggleIn transition sampled at edge k SHALL increment that channel's counter at edge k+SYNC_STAGES; latency to eventValid from an idle block SHALL be SYNC_STAGES+1 edges.
REQ-016 Counters SHALL saturate at 2^COUNT_WIDTH-1; a detect at saturation without a same-cycle accept SHALL drop the event and set overflow[ch].
REQ-017 Same-cycle detect and accept on one channel SHALL leave its counter unchanged and SHALL NOT set overflow.
REQ-018 Output FSM SHALL have states IDLE (eventValid=0) and PRESENT (eventValid=1).
REQ-019 IDLE->PRESENT SHALL occur on the edge after any counter is nonzero; the selected channel is loaded into eventChannel and its counter decremented on that edge.
REQ-020 Selection SHALL be round-robin: search starts at lastGranted+1, wrapping modulo CHANNELS.
REQ-021 In PRESENT without eventReady, eventValid and eventChannel SHALL hold stable.
REQ-022 In PRESENT with eventReady, lastGranted SHALL update to eventChannel; if any counter is nonzero (using post-update counts) the next channel SHALL be loaded and state stays PRESENT (back-to-back, one event per cycle), else state returns to IDLE.
REQ-023 The reserved (already decremented) event SHALL NOT be counted in pendingAny; pendingAny reflects counters only.
REQ-024 overflowClear SHALL clear all overflow bits on the next edge; a same-cycle new overflow SHALL win (bit set).
REQ-025 With CHANNELS=1, eventChannel SHALL be constant 0 and round-robin SHALL degenerate to always channel 0.

Reset
REQ-026 resetN low SHALL asynchronously clear all synchronizer, history and counter flops, overflow=0, eventValid=0, eventChannel=0, state IDLE, lastGranted=CHANNELS-1 (first grant favours channel 0).
REQ-027 A toggleIn bit at 1 when resetN deasserts SHALL produce exactly one event on that channel.
REQ-028 Reset asserted mid-PRESENT SHALL discard the presented and all pending events; no event SHALL appear after release unless REQ-027 applies.

Verification
REQ-029 Defaults, eventReady=1, toggle toggleIn[2] once at edge 10 -> eventValid high at edge 13 for one cycle, eventChannel=2, pendingAny 0 after.
REQ-030 eventReady=0, toggle toggleIn[0] 3 times spaced 4 cycles -> eventValid held with channel 0, counter=2; raise eventReady -> exactly 3 accepts, channel 0 each.
REQ-031 eventReady=0, toggle toggleIn[1] 17 times (COUNT_WIDTH=4) -> counter 15 plus one presented, overflow[1]=1 after 17th; pulse overflowClear -> overflow=0.
REQ-032 All four channels toggled once simultaneously, eventReady=1 -> accepted channels 0,1,2,3 on consecutive cycles; repeat -> same order.
REQ-033 Channel 3 pending with lastGranted=3 and channels 0,3 pending -> next grant is 0, then 3.
REQ-034 resetN pulsed low while eventValid=1 with 5 pending -> outputs 0 immediately, no events after release with toggleIn=0.
